// File: rtl/adder_seq_pkg.sv
// Shared definitions for the adder and its request sequencer.
// Function codes are common to both sides of the adder interface.
package adder_seq_pkg;

    localparam logic [1:0] F_UNS  = 2'b00;
    localparam logic [1:0] F_ONES = 2'b01;
    localparam logic [1:0] F_TWOS = 2'b10;
    localparam logic [1:0] F_ILL  = 2'b11;

    function automatic logic f_legal(input logic [1:0] f);
        return f != F_ILL;
    endfunction

endpackage

// File: rtl/adder.sv
// Registered adder: unsigned, ones-complement and twos-complement add.
// Result appears on y_o one cycle after f_i/a_i/b_i.
module adder
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       f_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] y_d;

    // Combinational result; ones-complement folds the carry back in.
    always_comb begin
        sum = {1'b0, a_i} + {1'b0, b_i};
        y_d = '0;
        unique case (f_i)
            F_UNS, F_TWOS: y_d = sum[WIDTH-1:0];
            F_ONES:        y_d = sum[WIDTH-1:0]
                               + {{(WIDTH-1){1'b0}}, sum[WIDTH]};
            default:       y_d = '0;
        endcase
    end

    // One-cycle registered latency.
    always_ff @(posedge clk) begin
        if (rst) y_o <= '0;
        else     y_o <= y_d;
    end

endmodule

// File: rtl/adder_seq_fifo.sv
// Small synchronous response FIFO for the adder sequencer.
// Reads are gated to zero when empty so idle outputs stay quiet.
module adder_seq_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Status flags and guarded push/pop strobes.
    always_comb begin
        full     = count == CW'(DEPTH);
        empty    = count == '0;
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        pop_data = empty ? '0 : mem[rd_ptr];
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; empty entries are never exposed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/adder_seq.sv
// Request sequencer in front of the registered adder.
// One request in flight; results return in order via a FIFO.
module adder_seq
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_f_i,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    output logic [1:0]       add_f_o,
    output logic [WIDTH-1:0] add_a_o,
    output logic [WIDTH-1:0] add_b_o,
    input  logic [WIDTH-1:0] add_y_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_y_o,
    output logic             rsp_err_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]    state;
    logic [1:0]    state_d;
    logic          err_q;
    logic          accept;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [WIDTH:0] push_data;
    logic [WIDTH:0] head;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next state: accept, then issue, then capture.
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:    if (accept) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Handshake strobes and FIFO push in the capture cycle.
    always_comb begin
        req_ready_o = (state == S_IDLE) && (count < CW'(DEPTH));
        accept      = req_valid_i & req_ready_o;
        push        = (state == S_CAPTURE) & ~full;
        push_data   = {(err_q ? {WIDTH{1'b0}} : add_y_i), err_q};
        pop         = ~empty & rsp_ready_i;
        rsp_valid_o = ~empty;
        rsp_y_o     = head[WIDTH:1];
        rsp_err_o   = head[0];
    end

    // Operand registers; illegal codes become a harmless 0+0.
    always_ff @(posedge clk) begin
        if (rst) begin
            add_f_o <= F_UNS;
            add_a_o <= '0;
            add_b_o <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            if (f_legal(req_f_i)) begin
                add_f_o <= req_f_i;
                add_a_o <= req_a_i;
                add_b_o <= req_b_i;
                err_q   <= 1'b0;
            end else begin
                add_f_o <= F_UNS;
                add_a_o <= '0;
                add_b_o <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    adder_seq_fifo #(
        .W     (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

endmodule

// File: tb/tb_adder_seq.sv
// Directed bench: adder_seq driving adder back-to-back.
// Expected values are hand-computed per vector.
module tb_adder_seq;
    import adder_seq_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_f = 2'b00;
    logic [WIDTH-1:0] req_a = '0;
    logic [WIDTH-1:0] req_b = '0;
    logic [1:0]       add_f;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_y;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_y;
    logic             rsp_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    adder_seq #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_f_i     (req_f),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .add_f_o     (add_f),
        .add_a_o     (add_a),
        .add_b_o     (add_b),
        .add_y_i     (add_y),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_y_o     (rsp_y),
        .rsp_err_o   (rsp_err)
    );

    adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .clk (clk),
        .rst (rst),
        .f_i (add_f),
        .a_i (add_a),
        .b_i (add_b),
        .y_o (add_y)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
        req_f     = 2'b11;
        req_a     = 4'hF;
        req_b     = 4'hF;
    endtask

    task automatic send(input logic [1:0] f,
                        input logic [3:0] a,
                        input logic [3:0] b,
                        input logic [3:0] y,
                        input logic       e);
        logic [1:0] ef;
        logic [3:0] ea;
        logic [3:0] eb;
        ef = e ? F_UNS : f;
        ea = e ? 4'h0 : a;
        eb = e ? 4'h0 : b;
        req_valid = 1'b1;
        req_f = f;
        req_a = a;
        req_b = b;
        check("acc_rdy", 32'(req_ready), 32'd1);
        cyc();
        idle_req();
        check("iss_f", 32'(add_f), 32'(ef));
        check("iss_a", 32'(add_a), 32'(ea));
        check("iss_b", 32'(add_b), 32'(eb));
        check("iss_rdy", 32'(req_ready), 32'd0);
        cyc();
        check("cap_vld", 32'(rsp_valid), 32'd0);
        cyc();
        check("rsp_vld", 32'(rsp_valid), 32'd1);
        check("rsp_y", 32'(rsp_y), 32'(y));
        check("rsp_err", 32'(rsp_err), 32'(e));
        check("rdy_t3", 32'(req_ready), 32'd1);
        check("hold_a", 32'(add_a), 32'(ea));
    endtask

    initial begin
        idle_req();
        rsp_ready = 1'b1;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        check("rst_rdy", 32'(req_ready), 32'd1);
        check("rst_vld", 32'(rsp_valid), 32'd0);
        check("rst_y", 32'(rsp_y), 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_f", 32'(add_f), 32'd0);
        check("rst_a", 32'(add_a), 32'd0);
        check("rst_b", 32'(add_b), 32'd0);

        send(F_UNS, 4'h9, 4'h8, 4'h1, 1'b0);
        send(F_ONES, 4'hE, 4'h3, 4'h2, 1'b0);
        send(F_TWOS, 4'h7, 4'h1, 4'h8, 1'b0);
        send(F_ONES, 4'h5, 4'h3, 4'h8, 1'b0);
        send(F_ILL, 4'h5, 4'h6, 4'h0, 1'b1);
        cyc();
        check("drain", 32'(rsp_valid), 32'd0);

        // Backpressure: three requests, FIFO of two.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_f = F_UNS;
        req_a = 4'h1;
        req_b = 4'h1;
        check("bp_rdy0", 32'(req_ready), 32'd1);
        cyc();
        req_a = 4'h2;
        req_b = 4'h2;
        check("bp_iss", 32'(req_ready), 32'd0);
        cyc();
        check("bp_cap", 32'(req_ready), 32'd0);
        cyc();
        check("bp_rdy1", 32'(req_ready), 32'd1);
        check("bp_y1", 32'(rsp_y), 32'd2);
        cyc();
        req_a = 4'h3;
        req_b = 4'h3;
        cyc();
        cyc();
        check("bp_full", 32'(req_ready), 32'd0);
        check("bp_hd", 32'(rsp_y), 32'd2);
        cyc();
        check("bp_held", 32'(req_ready), 32'd0);
        check("bp_stbl", 32'(rsp_y), 32'd2);
        check("bp_vld", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        check("bp_rdy2", 32'(req_ready), 32'd1);
        check("bp_y2", 32'(rsp_y), 32'd4);
        cyc();
        idle_req();
        check("bp_y2h", 32'(rsp_y), 32'd4);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        check("bp_emp", 32'(rsp_valid), 32'd0);
        cyc();
        check("bp_vld3", 32'(rsp_valid), 32'd1);
        check("bp_y3", 32'(rsp_y), 32'd6);
        rsp_ready = 1'b1;
        cyc();
        check("bp_done", 32'(rsp_valid), 32'd0);

        // Simultaneous push and pop with one entry queued.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_f = F_UNS;
        req_a = 4'h5;
        req_b = 4'h1;
        cyc();
        idle_req();
        cyc();
        cyc();
        check("pp_y1", 32'(rsp_y), 32'd6);
        req_valid = 1'b1;
        req_f = F_TWOS;
        req_a = 4'h2;
        req_b = 4'h3;
        check("pp_rdy", 32'(req_ready), 32'd1);
        cyc();
        idle_req();
        cyc();
        check("pp_hd", 32'(rsp_y), 32'd6);
        rsp_ready = 1'b1;
        cyc();
        check("pp_vld", 32'(rsp_valid), 32'd1);
        check("pp_y2", 32'(rsp_y), 32'd5);
        cyc();
        check("pp_emp", 32'(rsp_valid), 32'd0);

        // Reset during ISSUE with one response queued.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_f = F_UNS;
        req_a = 4'h4;
        req_b = 4'h4;
        cyc();
        idle_req();
        cyc();
        cyc();
        check("mr_q", 32'(rsp_y), 32'd8);
        req_valid = 1'b1;
        req_f = F_UNS;
        req_a = 4'h1;
        req_b = 4'h2;
        cyc();
        idle_req();
        check("mr_iss", 32'(add_a), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mr_vld", 32'(rsp_valid), 32'd0);
        check("mr_rdy", 32'(req_ready), 32'd1);
        check("mr_a", 32'(add_a), 32'd0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("mr_none", 32'(rsp_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
